tv_check_engine: RTL and testbench
==================================

// Module: tv_check_engine
// PURPOSE
//   Synthesizable, parametrised self-checking vector engine: holds a table of stimulus/expected/mask
//   vectors, drives each stimulus onto a DUT, samples the DUT response after a settle delay,
//   compares it under a bit mask, and reports error count, first-failure details and pass/done.
//   It is the hardware successor of our single-bit file-driven benches: same apply/compare/count
//   flow, generalised in width and depth, with masking and capture. Used for on-board checks of MIPS datapath blocks.
// PARAMETERS
//   IN_W    1   DUT stimulus width (bits)
//   OUT_W   1   DUT response width (bits)
//   DEPTH   16  vector table entries (>=1)
//   SETTLE  0   idle cycles between stimulus update and response sample (>=0)
//   ERR_W   8   error counter width; saturates at 2**ERR_W-1
// PORTS
//   clk        in   1                      clock, all logic on rising edge
//   rst        in   1                      synchronous, active-high reset
//   wr_en      in   1                      table write strobe (honoured only when busy=0)
//   wr_addr    in   $clog2(DEPTH)          table write index
//   wr_data    in   IN_W+2*OUT_W           {stim, exp, mask}; mask bit 1 = compare that output bit
//   num_vec    in   $clog2(DEPTH+1)        vectors to run; sampled at start
//   start      in   1                      begin run (honoured in IDLE and DONE only)
//   dut_in     out  IN_W                   registered stimulus to DUT
//   dut_out    in   OUT_W                  DUT response
//   busy       out  1                      run in progress
//   done       out  1                      run finished; held until start or rst
//   pass       out  1                      done & err_cnt==0
//   err_cnt    out  ERR_W                  mismatching vectors, saturating
//   vec_cnt    out  $clog2(DEPTH+1)        vectors checked in current/last run
//   ferr_vld   out  1                      a first failure has been captured
//   ferr_idx   out  $clog2(DEPTH)          index of first failing vector
//   ferr_got   out  OUT_W                  dut_out sampled at first failure
// BEHAVIOUR
//   Reset: FSM=IDLE; dut_in, err_cnt, vec_cnt, ferr_* = 0; busy=done=pass=0. Table contents not reset.
//   FSM: IDLE -> APPLY -> WAIT (SETTLE cycles; skipped if SETTLE=0) -> CHECK -> APPLY | DONE.
//   start in IDLE/DONE: clear err_cnt, vec_cnt, ferr_*, done; latch n = min(num_vec, DEPTH); idx=0.
//     n==0: go straight to DONE next cycle (pass=1, vec_cnt=0). Else -> APPLY.
//   APPLY (1 cycle): dut_in <= stim[idx] (visible to DUT from next cycle).
//   WAIT: count SETTLE cycles with dut_in stable.
//   CHECK (1 cycle): mismatch = |((dut_out ^ exp[idx]) & mask[idx]).
//     vec_cnt++; on mismatch err_cnt++ (hold at max); if !ferr_vld capture ferr_idx=idx, ferr_got=dut_out, ferr_vld=1.
//     idx==n-1 -> DONE, else idx++ -> APPLY.
//   Per-vector latency SETTLE+2 cycles; run of n vectors sets done SETTLE+2 cycles after last APPLY entry... i.e. n*(SETTLE+2)+1 cycles after start.
//   busy=1 in APPLY/WAIT/CHECK. done, pass, counters and ferr_* hold in DONE; dut_in holds last stimulus.
//   mask=0 vector always passes. wr_en while busy ignored (table unchanged). start while busy ignored.
//   wr_en and start same cycle in IDLE: write takes effect; run reads updated entry.
//   rst mid-run: abort immediately to reset state; table retained, rerun possible with start.
// TESTING
//   1 IN_W=OUT_W=1, DUT=inverter, table {0,1,1},{1,0,1}, n=2 -> done, pass=1, err_cnt=0, vec_cnt=2.
//   2 Same, entry1 exp=1 -> err_cnt=1, ferr_vld=1, ferr_idx=1, ferr_got=0, pass=0.
//   3 OUT_W=4, exp=4'hF, dut_out=4'h0, mask=4'h0 -> passes; mask=4'h1 -> fails.
//   4 ERR_W=2, 5 failing vectors -> err_cnt=3 (saturated), vec_cnt=5, ferr_idx=0.
//   5 num_vec=0 -> done=1, pass=1 one cycle after start; num_vec=DEPTH+1 -> vec_cnt=DEPTH.
//   6 SETTLE=3, rst asserted in WAIT -> all outputs 0 next cycle; restart yields same results as clean run.

Source files
------------

// File: rtl/tv_check_engine.sv
// Table-driven self-checking engine: applies stored stimulus to a DUT, waits SETTLE cycles,
// compares the masked response, and reports error count, first-failure capture and pass/done.
module tv_check_engine #(
  parameter int unsigned IN_W   = 1,
  parameter int unsigned OUT_W  = 1,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned SETTLE = 0,
  parameter int unsigned ERR_W  = 8,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned NW    = $clog2(DEPTH + 1),
  localparam int unsigned DW    = IN_W + 2 * OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic [NW-1:0]    num_vec,
  input  logic             start,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [NW-1:0]    vec_cnt,
  output logic             ferr_vld,
  output logic [AW-1:0]    ferr_idx,
  output logic [OUT_W-1:0] ferr_got
);

  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {StIdle, StApply, StWait, StCheck, StDone} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [NW-1:0]    n_q, n_d;
  logic [SW-1:0]    wait_q, wait_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [NW-1:0]    vec_q, vec_d;
  logic             ferr_vld_q, ferr_vld_d;
  logic [AW-1:0]    ferr_idx_q, ferr_idx_d;
  logic [OUT_W-1:0] ferr_got_q, ferr_got_d;

  logic [DW-1:0]    table_q [DEPTH];
  logic [DW-1:0]    entry;
  logic [IN_W-1:0]  entry_stim;
  logic [OUT_W-1:0] entry_exp;
  logic [OUT_W-1:0] entry_mask;
  logic             mismatch;

  assign busy = (state_q == StApply) || (state_q == StWait) || (state_q == StCheck);
  assign done = (state_q == StDone);
  assign pass = done && (err_q == '0);

  assign dut_in   = dut_in_q;
  assign err_cnt  = err_q;
  assign vec_cnt  = vec_q;
  assign ferr_vld = ferr_vld_q;
  assign ferr_idx = ferr_idx_q;
  assign ferr_got = ferr_got_q;

  // Table is deliberately outside the reset domain so a run can be repeated after rst.
  always_ff @(posedge clk) begin
    if (wr_en && !busy && (32'(wr_addr) < DEPTH)) begin
      table_q[wr_addr] <= wr_data;
    end
  end

  assign entry      = table_q[idx_q];
  assign entry_stim = entry[DW-1 -: IN_W];
  assign entry_exp  = entry[2*OUT_W-1 -: OUT_W];
  assign entry_mask = entry[OUT_W-1:0];
  assign mismatch   = |((dut_out ^ entry_exp) & entry_mask);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    wait_d     = wait_q;
    dut_in_d   = dut_in_q;
    err_d      = err_q;
    vec_d      = vec_q;
    ferr_vld_d = ferr_vld_q;
    ferr_idx_d = ferr_idx_q;
    ferr_got_d = ferr_got_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          err_d      = '0;
          vec_d      = '0;
          ferr_vld_d = 1'b0;
          ferr_idx_d = '0;
          ferr_got_d = '0;
          idx_d      = '0;
          if (num_vec > NW'(DEPTH)) n_d = NW'(DEPTH);
          else                      n_d = num_vec;
          state_d = (num_vec == '0) ? StDone : StApply;
        end
      end
      StApply: begin
        dut_in_d = entry_stim;
        wait_d   = '0;
        state_d  = (SETTLE == 0) ? StCheck : StWait;
      end
      StWait: begin
        if (wait_q == SW'(SETTLE - 1)) state_d = StCheck;
        else                           wait_d  = wait_q + 1'b1;
      end
      StCheck: begin
        vec_d = vec_q + 1'b1;
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + 1'b1;
          if (!ferr_vld_q) begin
            ferr_vld_d = 1'b1;
            ferr_idx_d = idx_q;
            ferr_got_d = dut_out;
          end
        end
        if (vec_d == n_q) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StApply;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      n_q        <= '0;
      wait_q     <= '0;
      dut_in_q   <= '0;
      err_q      <= '0;
      vec_q      <= '0;
      ferr_vld_q <= 1'b0;
      ferr_idx_q <= '0;
      ferr_got_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      wait_q     <= wait_d;
      dut_in_q   <= dut_in_d;
      err_q      <= err_d;
      vec_q      <= vec_d;
      ferr_vld_q <= ferr_vld_d;
      ferr_idx_q <= ferr_idx_d;
      ferr_got_q <= ferr_got_d;
    end
  end

endmodule

// File: tb/tb_tv_check_engine.sv
// Bench for tv_check_engine: a 1-bit inverter instance with no settle delay, and a 4-bit
// instance with SETTLE=3 driving a 3-stage pipelined DUT, checked against a table model.
module tb_tv_check_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instance A: 1-bit, DEPTH=4, SETTLE=0, DUT is an inverter
  logic       a_rst, a_wr_en, a_start, a_dut_in, a_dut_out;
  logic       a_busy, a_done, a_pass, a_ferr_vld, a_ferr_got;
  logic [1:0] a_wr_addr, a_ferr_idx;
  logic [2:0] a_wr_data, a_num_vec, a_vec_cnt;
  logic [7:0] a_err_cnt;

  assign a_dut_out = ~a_dut_in;

  tv_check_engine #(.IN_W(1), .OUT_W(1), .DEPTH(4), .SETTLE(0), .ERR_W(8)) u_a (
    .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .num_vec(a_num_vec), .start(a_start), .dut_in(a_dut_in), .dut_out(a_dut_out),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_cnt(a_err_cnt), .vec_cnt(a_vec_cnt),
    .ferr_vld(a_ferr_vld), .ferr_idx(a_ferr_idx), .ferr_got(a_ferr_got)
  );

  // Instance B: 4-bit, DEPTH=8, SETTLE=3, ERR_W=2; DUT is (in ^ 4'hA) through 3 registers
  logic       b_rst, b_wr_en, b_start, b_busy, b_done, b_pass, b_ferr_vld;
  logic [2:0] b_wr_addr, b_ferr_idx;
  logic [11:0] b_wr_data;
  logic [3:0] b_num_vec, b_vec_cnt, b_dut_in, b_dut_out, b_ferr_got;
  logic [1:0] b_err_cnt;
  logic [3:0] p1 = 4'h0, p2 = 4'h0, p3 = 4'h0;

  always @(posedge clk) begin
    p1 <= b_dut_in ^ 4'hA;
    p2 <= p1;
    p3 <= p2;
  end
  assign b_dut_out = p3;

  tv_check_engine #(.IN_W(4), .OUT_W(4), .DEPTH(8), .SETTLE(3), .ERR_W(2)) u_b (
    .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .num_vec(b_num_vec), .start(b_start), .dut_in(b_dut_in), .dut_out(b_dut_out),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err_cnt), .vec_cnt(b_vec_cnt),
    .ferr_vld(b_ferr_vld), .ferr_idx(b_ferr_idx), .ferr_got(b_ferr_got)
  );

  // Reference table for instance B
  logic [3:0] m_stim [8];
  logic [3:0] m_exp  [8];
  logic [3:0] m_mask [8];
  logic [3:0] m_last = 4'h0;

  // ---------------- instance A helpers ----------------
  task automatic a_write(input logic [1:0] addr, input logic [2:0] data);
    a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
    @(negedge clk);
    a_wr_en = 1'b0;
  endtask

  task automatic a_run(input int num, input int e_err, input int e_vec, input int e_fv,
                       input int e_fi, input int e_fg);
    int cyc;
    int nn;
    nn = (num > 4) ? 4 : num;
    a_num_vec = 3'(num); a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; cyc = 1;
    while (!a_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("a_latency", 64'(cyc), 64'(nn * 2 + 1));
    check_eq("a_done", 64'(a_done), 64'(1));
    check_eq("a_busy", 64'(a_busy), 64'(0));
    check_eq("a_pass", 64'(a_pass), 64'(e_err == 0));
    check_eq("a_err_cnt", 64'(a_err_cnt), 64'(e_err));
    check_eq("a_vec_cnt", 64'(a_vec_cnt), 64'(e_vec));
    check_eq("a_ferr_vld", 64'(a_ferr_vld), 64'(e_fv));
    check_eq("a_ferr_idx", 64'(a_ferr_idx), 64'(e_fi));
    check_eq("a_ferr_got", 64'(a_ferr_got), 64'(e_fg));
  endtask

  // ---------------- instance B helpers ----------------
  function automatic logic [11:0] rand_entry();
    logic [3:0] s, e, m;
    s = 4'($urandom);
    e = ($urandom_range(1, 0) == 1) ? (s ^ 4'hA) : 4'($urandom);
    case ($urandom_range(3, 0))
      0:       m = 4'h0;
      1:       m = 4'hF;
      default: m = 4'($urandom);
    endcase
    return {s, e, m};
  endfunction

  task automatic b_write(input int addr, input logic [11:0] data);
    b_wr_en = 1'b1; b_wr_addr = 3'(addr); b_wr_data = data;
    {m_stim[addr], m_exp[addr], m_mask[addr]} = data;
    @(negedge clk);
    b_wr_en = 1'b0;
  endtask

  task automatic b_check_zero(input string tag);
    check_eq({tag, "_outs"},
             {b_busy, b_done, b_pass, b_ferr_vld, b_err_cnt, b_vec_cnt, b_ferr_idx, b_ferr_got,
              b_dut_in},
             64'(0));
  endtask

  // wr_with_start: write entry 0 in the start cycle; poke: try a write and a start mid-run
  task automatic b_run(input int num, input bit wr_with_start, input bit poke);
    logic [11:0] ent;
    logic [3:0]  got, fg;
    int          nn, nerr, fi, cyc;
    bit          fv;
    if (wr_with_start) begin
      ent = rand_entry();
      b_wr_en = 1'b1; b_wr_addr = 3'd0; b_wr_data = ent;
      {m_stim[0], m_exp[0], m_mask[0]} = ent;
    end
    nn = (num > 8) ? 8 : num;
    nerr = 0; fv = 1'b0; fi = 0; fg = 4'h0;
    for (int i = 0; i < nn; i++) begin
      got = m_stim[i] ^ 4'hA;
      if (((got ^ m_exp[i]) & m_mask[i]) != 4'h0) begin
        nerr++;
        if (!fv) begin fv = 1'b1; fi = i; fg = got; end
      end
    end
    if (nn > 0) m_last = m_stim[nn-1];

    b_num_vec = 4'(num); b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0; b_wr_en = 1'b0; cyc = 1;
    while (!b_done && cyc < 200) begin
      if (poke && cyc == 2) begin
        b_wr_en = 1'b1; b_wr_addr = 3'($urandom); b_wr_data = 12'($urandom); b_start = 1'b1;
      end else begin
        b_wr_en = 1'b0; b_start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    b_wr_en = 1'b0; b_start = 1'b0;
    check_eq("b_latency", 64'(cyc), 64'(nn * 5 + 1));
    check_eq("b_done", 64'(b_done), 64'(1));
    check_eq("b_busy", 64'(b_busy), 64'(0));
    check_eq("b_pass", 64'(b_pass), 64'(nerr == 0));
    check_eq("b_err_cnt", 64'(b_err_cnt), 64'((nerr > 3) ? 3 : nerr));
    check_eq("b_vec_cnt", 64'(b_vec_cnt), 64'(nn));
    check_eq("b_ferr_vld", 64'(b_ferr_vld), 64'(fv));
    check_eq("b_ferr_idx", 64'(b_ferr_idx), 64'(fi));
    check_eq("b_ferr_got", 64'(b_ferr_got), 64'(fg));
    check_eq("b_dut_in", 64'(b_dut_in), 64'(m_last));
  endtask

  task automatic b_abort(input int after);
    b_num_vec = 4'd8; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    repeat (after - 1) @(negedge clk);
    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;
    m_last = 4'h0;
    b_check_zero("b_abort");
  endtask

  initial begin
    a_rst = 1'b1; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_num_vec = '0; a_start = 1'b0;
    b_rst = 1'b1; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_num_vec = '0; b_start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("a_reset_outs",
             {a_busy, a_done, a_pass, a_ferr_vld, a_err_cnt, a_vec_cnt, a_ferr_idx, a_ferr_got,
              a_dut_in},
             64'(0));
    b_check_zero("b_reset");
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);

    // Inverter: {stim, exp, mask}
    a_write(2'd0, 3'b011);
    a_write(2'd1, 3'b101);
    a_run(2, 0, 2, 0, 0, 0);
    a_write(2'd1, 3'b111);
    a_run(2, 1, 2, 1, 1, 0);
    a_run(0, 0, 0, 0, 0, 0);
    a_write(2'd1, 3'b101);
    a_write(2'd2, 3'b011);
    a_write(2'd3, 3'b101);
    a_run(5, 0, 4, 0, 0, 0);

    // Instance B: mask=0 passes, single-bit mask catches a mismatch
    for (int i = 0; i < 8; i++) b_write(i, rand_entry());
    b_write(0, {4'h5, 4'hF, 4'h0});
    b_run(1, 1'b0, 1'b0);
    b_write(0, {4'h5, 4'h5, 4'h2});
    b_run(1, 1'b0, 1'b0);
    // Five failing vectors saturate a 2-bit counter
    for (int i = 0; i < 5; i++) b_write(i, {4'(i), 4'(i) ^ 4'h5, 4'hF});
    b_run(5, 1'b0, 1'b0);
    b_run(9, 1'b0, 1'b0);

    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(1, 0) == 1) b_write(int'($urandom_range(7, 0)), rand_entry());
      b_run(int'($urandom_range(9, 0)), $urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1);
    end

    b_abort(3);
    b_run(8, 1'b0, 1'b0);
    b_abort(int'($urandom_range(30, 2)));
    b_run(8, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
